// File: rtl/display_scan_controller_pkg.sv
// Shared types and constants for the multiplexed 4-digit display scanner.
package display_scan_controller_pkg;

    typedef enum logic {
        GAP  = 1'b0,
        SHOW = 1'b1
    } scan_state_e;

    localparam logic [3:0]  BLANK_CODE = 4'hA;
    localparam int unsigned NUM_DIGITS = 4;

    // Nibble presented for digit idx: blank when it is a leading zero (lz_en) or
    // in the off half of a blink; everything else, including A-F, passes through.
    function automatic logic [3:0] digit_code(
        input logic [15:0] value,
        input logic [1:0]  idx,
        input logic        lz_en,
        input logic [3:0]  blink_mask,
        input logic        blink_phase
    );
        logic [3:0] nib;
        logic       z3, z2, z1;
        logic       suppress;
        nib = value[{idx, 2'b00} +: 4];
        z3  = (value[15:12] == 4'h0);
        z2  = z3 && (value[11:8] == 4'h0);
        z1  = z2 && (value[7:4] == 4'h0);
        case (idx)
            2'd3:    suppress = z3;
            2'd2:    suppress = z2;
            2'd1:    suppress = z1;
            default: suppress = 1'b0;
        endcase
        if ((lz_en && suppress) || (blink_phase && blink_mask[idx]))
            digit_code = BLANK_CODE;
        else
            digit_code = nib;
    endfunction

endpackage

// File: rtl/display_scan_controller_scan_timer.sv
// Phase timer: counts the lit (SCAN_DIV) or blank (BLANK_CYC) interval and pulses on its last cycle.
module scan_timer
    import display_scan_controller_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  scan_state_e state,
    output logic        phase_done
);

    localparam int unsigned MAX_CYC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        phase_done = (cnt_q == ((state == SHOW) ? SHOW_LAST : BLANK_LAST));
        cnt_d      = phase_done ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed 4-digit display scanner with frame-aligned value load,
// leading-zero suppression and per-digit blink.
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYC    = 16,
    parameter int unsigned BLINK_FRAMES = 128
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_data,
    input  logic        lz_en,
    input  logic [3:0]  blink_mask,
    output logic [3:0]  an_n,
    output logic [3:0]  dig_code,
    output logic        frame_start
);

    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned FW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [IDX_W-1:0] LAST_DIGIT = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FW-1:0]    FRAME_LAST = FW'(BLINK_FRAMES - 1);

    scan_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       an_n_q, an_n_d;
    logic [3:0]       dig_code_q, dig_code_d;
    logic             frame_start_q, frame_start_d;
    logic             pending_q, pending_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [15:0]      active_q, active_d;
    logic [FW-1:0]    frame_cnt_q, frame_cnt_d;
    logic             blink_phase_q, blink_phase_d;
    logic             phase_done;

    scan_timer #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_scan_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .state      (state_q),
        .phase_done (phase_done)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        an_n_d        = an_n_q;
        dig_code_d    = dig_code_q;
        frame_start_d = 1'b0;
        pending_d     = pending_q;
        shadow_d      = shadow_q;
        active_d      = active_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;

        if (load_valid && !pending_q) begin
            shadow_d  = load_data;
            pending_d = 1'b1;
        end

        if (frame_start_q) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d   = '0;
                blink_phase_d = !blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end

        // Outputs are computed from the next state so the registered copies
        // switch on the same edge as the state itself.
        if (phase_done) begin
            unique case (state_q)
                GAP: begin
                    state_d = SHOW;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_DIGIT) begin
                        frame_start_d = 1'b1;
                        if (pending_q) begin
                            active_d  = shadow_q;
                            pending_d = 1'b0;
                        end
                    end
                    an_n_d     = ~(4'b0001 << idx_d);
                    dig_code_d = digit_code(active_d, idx_d, lz_en, blink_mask, blink_phase_q);
                end
                SHOW: begin
                    state_d    = GAP;
                    an_n_d     = '1;
                    dig_code_d = BLANK_CODE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= GAP;
            idx_q         <= LAST_DIGIT;
            an_n_q        <= '1;
            dig_code_q    <= BLANK_CODE;
            frame_start_q <= 1'b0;
            pending_q     <= 1'b0;
            shadow_q      <= '0;
            active_q      <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            an_n_q        <= an_n_d;
            dig_code_q    <= dig_code_d;
            frame_start_q <= frame_start_d;
            pending_q     <= pending_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign load_ready  = !pending_q;
    assign an_n        = an_n_q;
    assign dig_code    = dig_code_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench: per-frame digit expectations are queued as stimulus is applied
// and popped at the first lit cycle of every digit.
module tb_display_scan_controller;

    localparam int unsigned SCAN_DIV     = 4;
    localparam int unsigned BLANK_CYC    = 2;
    localparam int unsigned BLINK_FRAMES = 2;
    localparam int          FRAME_CYC    = 4 * (SCAN_DIV + BLANK_CYC);

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_data = '0;
    logic        lz_en = 1'b0;
    logic [3:0]  blink_mask = '0;
    logic [3:0]  an_n;
    logic [3:0]  dig_code;
    logic        frame_start;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          cyc = 0;
    int          frame_n = 0;
    logic        mon_en = 1'b0;
    logic [15:0] m_active = '0;
    logic        m_lz = 1'b0;
    logic [3:0]  m_mask = '0;
    logic [7:0]  exp_q[$];

    display_scan_controller #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYC    (BLANK_CYC),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .lz_en       (lz_en),
        .blink_mask  (blink_mask),
        .an_n        (an_n),
        .dig_code    (dig_code),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_code(input logic [15:0] v, input int i,
                                            input logic lz, input logic [3:0] m, input int n);
        logic [15:0] hi;
        int          ph;
        hi = v >> (4 * i);
        ph = (((i == 0) ? n - 1 : n) / BLINK_FRAMES) % 2;
        if (lz && i != 0 && hi == 16'h0) return 4'hA;
        if (ph == 1 && m[i]) return 4'hA;
        return hi[3:0];
    endfunction

    task automatic push_frame(input int n);
        logic [3:0] an;
        for (int i = 0; i < 4; i++) begin
            an = ~(4'b0001 << i);
            exp_q.push_back({an, exp_code(m_active, i, m_lz, m_mask, n)});
        end
    endtask

    task automatic wait_fs();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (frame_start) begin
                seen = 1'b1;
                break;
            end
        end
        check("frame_start_seen", seen, 1);
    endtask

    task automatic mid_frame();
        wait_fs();
        repeat (19) @(negedge clk);
        frame_n++;
    endtask

    task automatic do_load(input logic [15:0] v);
        check("ready_before_load", load_ready, 1);
        load_data  = v;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        m_active   = v;
        check("ready_low_after_load", load_ready, 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        mon_en = 1'b0;
    endtask

    // Digit-start scoreboard and frame period monitor
    logic [3:0] prev_an = 4'hF;
    int         prev_fs = 0;
    logic       have_prev = 1'b0;
    logic [7:0] e;
    always @(negedge clk) begin
        if (mon_en && an_n != 4'hF && prev_an == 4'hF) begin
            check("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("digit", {an_n, dig_code}, e);
                check("fs_align", frame_start, e[7:4] == 4'b1110);
            end
        end
        if (mon_en && frame_start) begin
            if (have_prev) check("frame_period", cyc - prev_fs, FRAME_CYC);
            prev_fs   = cyc;
            have_prev = 1'b1;
        end
        if (!mon_en) have_prev = 1'b0;
        prev_an = an_n;
    end

    initial begin
        logic       seen;
        logic [4:0] exp_cyc;
        int         k;

        repeat (3) @(negedge clk);
        check("rst_an_n", an_n, 4'hF);
        check("rst_dig_code", dig_code, 4'hA);
        check("rst_frame_start", frame_start, 0);
        check("rst_load_ready", load_ready, 1);

        push_frame(1);
        push_frame(2);
        mon_en  = 1'b1;
        reset_n = 1'b1;
        for (int i = 0; i < FRAME_CYC; i++) begin
            #1;
            exp_cyc[4:1] = ((i % 6) < 2) ? 4'hF : ~(4'b0001 << (i / 6));
            exp_cyc[0]   = (i == 2);
            check("first_frame_cycle", {an_n, frame_start}, exp_cyc);
            @(negedge clk);
        end
        frame_n = 1;

        // Load during frame 2; a second offer must wait for the commit
        mid_frame();
        check("ready_idle", load_ready, 1);
        load_data  = 16'h1234;
        load_valid = 1'b1;
        @(negedge clk);
        load_data = 16'h5678;
        check("ready_low_pending", load_ready, 0);
        m_active = 16'h1234;
        push_frame(frame_n + 1);
        seen = 1'b0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (load_ready) begin
                seen = 1'b1;
                break;
            end
        end
        check("ready_rise", seen, 1);
        check("ready_at_frame_start", frame_start, 1);
        @(negedge clk);
        load_valid = 1'b0;
        check("ready_low_second", load_ready, 0);
        frame_n++;
        repeat (18) @(negedge clk);
        m_active = 16'h5678;
        push_frame(frame_n + 1);

        // Leading-zero suppression
        mid_frame();
        m_lz  = 1'b1;
        lz_en = 1'b1;
        do_load(16'h0050);
        push_frame(frame_n + 1);

        mid_frame();
        do_load(16'h0000);
        push_frame(frame_n + 1);

        // Blink on digit 0
        mid_frame();
        m_lz       = 1'b0;
        lz_en      = 1'b0;
        m_mask     = 4'b0001;
        blink_mask = 4'b0001;
        do_load(16'h1234);
        push_frame(frame_n + 1);
        for (int f = 0; f < 3; f++) begin
            mid_frame();
            push_frame(frame_n + 1);
        end

        // Hex pass-through mixed with suppression
        mid_frame();
        m_mask     = 4'b0000;
        blink_mask = 4'b0000;
        m_lz       = 1'b1;
        lz_en      = 1'b1;
        do_load(16'h0F0A);
        push_frame(frame_n + 1);
        drain();

        // Reset in the middle of digit 2 with a value pending
        wait_fs();
        repeat (12) @(negedge clk);
        do_load(16'h9999);
        check("pre_reset_an", an_n, 4'b1011);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_an_n", an_n, 4'hF);
        check("mid_rst_dig_code", dig_code, 4'hA);
        check("mid_rst_frame_start", frame_start, 0);
        check("mid_rst_load_ready", load_ready, 1);
        m_lz       = 1'b0;
        lz_en      = 1'b0;
        m_active   = 16'h0000;
        repeat (2) @(negedge clk);
        push_frame(1);
        push_frame(2);
        mon_en  = 1'b1;
        reset_n = 1'b1;
        k = 0;
        while (!frame_start && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("restart_latency", k, BLANK_CYC);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clock cycles each digit is lit (>=2).
REQ-002 SHALL have parameter BLANK_CYC, default 16, clock cycles of all-off gap between digits (>=1).
REQ-003 SHALL have parameter BLINK_FRAMES, default 128, full scan frames per blink half-period (>=1).
REQ-004 clk  in  1  single system clock; all state on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 load_valid  in  1  new display value offered.
REQ-007 load_ready  out  1  controller can accept a value.
REQ-008 load_data  in  16  four nibbles; digit3=[15:12] (leftmost) .. digit0=[3:0].
REQ-009 lz_en  in  1  leading-zero suppression enable.
REQ-010 blink_mask  in  4  per-digit blink enable, bit i = digit i.
REQ-011 an_n  out  4  digit enables, active-low, at most one low.
REQ-012 dig_code  out  4  nibble to the shared 4-bit-in/7-segment decoder; 4'hA = blank (all segments off).
REQ-013 frame_start  out  1  one-cycle pulse, first lit cycle of digit 0.

Function
REQ-014 FSM SHALL have two states: GAP (an_n=4'b1111, dig_code=4'hA) and SHOW (an_n[idx]=0, dig_code=displayed nibble).
REQ-015 GAP SHALL last exactly BLANK_CYC cycles, then idx<=(idx+1) mod 4 and enter SHOW.
REQ-016 SHOW SHALL last exactly SCAN_DIV cycles, then enter GAP; the frame period is 4*(SCAN_DIV+BLANK_CYC) cycles.
REQ-017 an_n, dig_code and frame_start SHALL be registered; they change in the same cycle the state changes.
REQ-018 Handshake: transfer occurs when load_valid && load_ready; data goes to a shadow register and sets pending.
REQ-019 load_ready SHALL equal !pending; load_valid with load_ready low is ignored, with no loss of the already-pending value.
REQ-020 Commit: on the GAP->SHOW transition with idx 3->0, if pending, active<=shadow and pending<=0; the displayed value never changes mid-frame.
REQ-021 Commit and accept SHALL never coincide (accept requires !pending); load_ready rises the cycle after commit.
REQ-022 lz_en, blink_mask and blink phase SHALL be sampled on each GAP->SHOW transition and held for that digit.
REQ-023 Leading-zero: with lz_en=1, digit i (i=3..1) SHALL show 4'hA if it and all higher digits of active are 0; digit 0 is never suppressed.
REQ-024 Blink: a frame counter increments at each frame_start and wraps at BLINK_FRAMES-1; at wrap the blink phase toggles.
REQ-025 When blink phase=1 and blink_mask[idx]=1, digit SHALL show 4'hA (an_n still asserted).
REQ-026 Nibble values 4'hA-4'hF in active SHALL pass through unmodified unless suppressed or blinked.
REQ-027 Counters SHALL be wide enough for their parameters, via $clog2, with no overflow at maximum values.

Reset
REQ-028 While reset_n=0: state=GAP, idx=3, an_n=4'b1111, dig_code=4'hA, frame_start=0, load_ready=1, pending=0, shadow=active=16'h0000, blink phase=0, all counters=0.
REQ-029 Reset asserted mid-SHOW SHALL force the above immediately; after release, the first SHOW is digit 0 with frame_start, BLANK_CYC cycles later.

Structure
REQ-030 The shared package SHALL hold the state encoding (GAP, SHOW), BLANK_CODE=4'hA and NUM_DIGITS=4.
REQ-031 Sub-module scan_timer SHALL contain the SCAN_DIV/BLANK_CYC cycle counter and emit a phase-done pulse; the 7-segment decoder stays external.

Verification (SCAN_DIV=4, BLANK_CYC=2, BLINK_FRAMES=2)
REQ-032 Reset release, no load -> an_n pattern 1111x2, 1110x4, 1111x2, 1101x4, ...; dig_code=0 when lit; frame_start every 24 cycles.
REQ-033 Load 16'h1234 mid-frame -> load_ready low until next frame_start; that frame shows 4,3,2,1 on an_n bits 0..3.
REQ-034 Second load 16'h5678 while pending -> not accepted; 16'h1234 is displayed; 16'h5678 is accepted once load_ready=1.
REQ-035 lz_en=1, active=16'h0050 -> digits 3 and 2 show 4'hA, digit 1=5, digit 0=0; active=16'h0000 -> digit 0=0, others 4'hA.
REQ-036 blink_mask=4'b0001, active=16'h1234 -> digit 0 alternates 4 and 4'hA every 2 frames; other digits are unaffected.
REQ-037 reset_n pulsed low during SHOW of digit 2 -> outputs are immediately 1111/4'hA and active=0; the sequence restarts per REQ-029.
